// File: rtl/regfile_dump.sv
// regfile_dump: walks the register file two registers per cycle through the
// asynchronous read ports and streams (address, data) words to a sink over
// a valid/ready handshake.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for Start, read addresses parked at 0
// S_READ    | read ports address pair p, both words captured at the edge
// S_SEND_LO | presenting the even register of pair p
// S_SEND_HI | presenting the odd register of pair p
// S_DONE    | one-cycle completion pulse, then back to idle
module regfile_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Start,
  output logic [ADDR_W-1:0] RdAdr1,
  output logic [ADDR_W-1:0] RdAdr2,
  input  logic [DATA_W-1:0] RdData1,
  input  logic [DATA_W-1:0] RdData2,
  output logic [DATA_W-1:0] OutData,
  output logic [ADDR_W-1:0] OutAdr,
  output logic              OutValid,
  input  logic              OutReady,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_SEND_LO,
    S_SEND_HI,
    S_DONE
  } state_t;

  // The pair counter only needs to span NUM_REGS/2 values.
  localparam int PW = ADDR_W - 1;
  localparam logic [PW-1:0] LAST_P = PW'(NUM_REGS / 2 - 1);

  state_t            state_q,    state_d;
  logic [PW-1:0]     p_q,        p_d;
  logic [DATA_W-1:0] buf0_q,     buf0_d;
  logic [DATA_W-1:0] buf1_q,     buf1_d;
  logic [ADDR_W-1:0] rd_adr1_q,  rd_adr1_d;
  logic [ADDR_W-1:0] rd_adr2_q,  rd_adr2_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [ADDR_W-1:0] out_adr_q,  out_adr_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;

  // Next-state, pair counter, capture buffers and registered output values.
  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;
    rd_adr1_d   = rd_adr1_q;
    rd_adr2_d   = rd_adr2_q;
    out_data_d  = out_data_q;
    out_adr_d   = out_adr_q;

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          p_d     = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        buf0_d     = RdData1;
        buf1_d     = RdData2;
        // Output register is loaded straight from the read port so the
        // even word appears in the same cycle the buffers become valid.
        out_data_d = RdData1;
        out_adr_d  = rd_adr1_q;
        state_d    = S_SEND_LO;
      end
      S_SEND_LO: begin
        if (OutReady) begin
          out_data_d = buf1_q;
          out_adr_d  = rd_adr2_q;
          state_d    = S_SEND_HI;
        end
      end
      S_SEND_HI: begin
        if (OutReady) begin
          if (p_q == LAST_P) begin
            state_d = S_DONE;
          end else begin
            p_d     = p_q + 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Read addresses change only when a READ is entered and are parked at
    // zero in idle; during the send states they keep the last pair.
    if (state_d == S_READ) begin
      rd_adr1_d = {p_d, 1'b0};
      rd_adr2_d = {p_d, 1'b1};
    end else if (state_d == S_IDLE) begin
      rd_adr1_d = '0;
      rd_adr2_d = '0;
    end

    out_valid_d = (state_d == S_SEND_LO) || (state_d == S_SEND_HI);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  // All state and outputs are flops; reset clears everything at once.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      p_q         <= '0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      rd_adr1_q   <= '0;
      rd_adr2_q   <= '0;
      out_data_q  <= '0;
      out_adr_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      rd_adr1_q   <= rd_adr1_d;
      rd_adr2_q   <= rd_adr2_d;
      out_data_q  <= out_data_d;
      out_adr_q   <= out_adr_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign RdAdr1   = rd_adr1_q;
  assign RdAdr2   = rd_adr2_q;
  assign OutData  = out_data_q;
  assign OutAdr   = out_adr_q;
  assign OutValid = out_valid_q;
  assign Busy     = busy_q;
  assign Done     = done_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump with a behavioural register file.
module tb_regfile_dump;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          Start;
  logic          OutReady;
  logic [AW-1:0] RdAdr1, RdAdr2, OutAdr;
  logic [DW-1:0] RdData1, RdData2, OutData;
  logic          OutValid, Busy, Done;

  logic [DW-1:0] regs [0:NR-1];

  assign RdData1 = regs[RdAdr1];
  assign RdData2 = regs[RdAdr2];

  regfile_dump #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start),
    .RdAdr1(RdAdr1), .RdAdr2(RdAdr2),
    .RdData1(RdData1), .RdData2(RdData2),
    .OutData(OutData), .OutAdr(OutAdr), .OutValid(OutValid),
    .OutReady(OutReady), .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit r20_written;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] exp_val(input int n);
    if (n == 0) return 32'hF0F0F0F0;
    if (n == 1) return 32'h0F0F0F0F;
    if (n == 2) return 32'hFFFFFFFF;
    if (n == 20 && r20_written) return 32'h12345678;
    return DW'(n);
  endfunction

  task automatic preload();
    for (int i = 0; i < NR; i++) regs[i] = DW'(i);
    regs[0] = 32'hF0F0F0F0;
    regs[1] = 32'h0F0F0F0F;
    regs[2] = 32'hFFFFFFFF;
    r20_written = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rdadr1"}, RdAdr1, 0);
    check({tag, "_rdadr2"}, RdAdr2, 0);
    check({tag, "_odata"}, OutData, 0);
    check({tag, "_oadr"}, OutAdr, 0);
    check({tag, "_ovalid"}, OutValid, 0);
    check({tag, "_busy"}, Busy, 0);
    check({tag, "_done"}, Done, 0);
  endtask

  // mode: 0 plain, 1 backpressure at word 1, 2 Start while busy,
  //       3 reset in SEND_HI of pair 7, 4 write R20 after pair 9
  task automatic dump(input int mode);
    int widx = 0, n = 0, first_n = -1, done_n = -1, done_cnt = 0;
    int stalls = 0, post = 0;
    bit hold_pend = 0, wr_pend = 0, aborted = 0, rdy;
    logic [AW-1:0] prev_adr = '0;
    logic [DW-1:0] prev_data = '0;
    preload();
    @(negedge Clk);
    Start = 1'b1;
    OutReady = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    while (n < 300 && !aborted && post < 3) begin
      @(negedge Clk);
      n++;
      Start = 1'b0;
      if (wr_pend) begin
        regs[20] = 32'h12345678;
        r20_written = 1'b1;
        wr_pend = 0;
      end
      if (done_cnt > 0) post++;
      if (hold_pend) begin
        check("hold_valid", OutValid, 1);
        check("hold_adr", OutAdr, prev_adr);
        check("hold_data", OutData, prev_data);
      end
      if (OutValid) begin
        if (first_n < 0) first_n = n;
        check("out_adr", OutAdr, widx);
        check("out_data", OutData, exp_val(widx));
      end else if (Busy && !Done) begin
        check("rd_adr1", RdAdr1, widx);
        check("rd_adr2", RdAdr2, widx + 1);
      end
      if (Done) begin
        done_cnt++;
        done_n = n;
        check("done_words", widx, NR);
        check("done_busy", Busy, 1);
        check("done_valid", OutValid, 0);
      end
      if (mode == 3 && OutValid && OutAdr == 15) begin
        Rst = 1'b1;
        #1 check_zero("rst_mid");
        aborted = 1;
      end else begin
        rdy = 1;
        if (mode == 1 && OutValid && OutAdr == 1 && stalls < 5) begin
          rdy = 0;
          stalls++;
        end
        OutReady = rdy;
        if (OutValid && rdy) begin
          if (mode == 4 && widx == 19) wr_pend = 1;
          if (mode == 2 && widx == 10) Start = 1'b1;
          widx++;
          hold_pend = 0;
        end else if (OutValid) begin
          hold_pend = 1;
          prev_adr = OutAdr;
          prev_data = OutData;
        end else begin
          hold_pend = 0;
        end
      end
    end
    if (mode == 3) begin
      @(negedge Clk);
      check_zero("rst_held");
      Rst = 1'b0;
    end else begin
      check("word_count", widx, NR);
      check("done_count", done_cnt, 1);
      check("done_cycle", done_n, 49 + stalls);
      check("first_valid", first_n, 2);
      check("busy_after", Busy, 0);
      if (mode == 1) check("stall_cycles", stalls, 5);
    end
  endtask

  initial begin
    Rst = 1'b0;
    Start = 1'b0;
    OutReady = 1'b0;
    preload();
    #3 Rst = 1'b1;
    #1 check_zero("rst_async");
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      check("idle_busy", Busy, 0);
      check("idle_valid", OutValid, 0);
    end
    dump(0);
    dump(1);
    dump(2);
    dump(3);
    dump(0);
    dump(4);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
Reader-side controller for the processor register file: on a Start pulse it walks every register through the two asynchronous read ports and streams the contents out as (address, data) words over a valid/ready handshake. It sits between register_file (driving Adr1/Adr2, consuming Dout1/Dout2) and a debug/trace sink such as a UART transmitter or a testbench scoreboard. It reads two registers per cycle and buffers each pair until the sink has consumed it.

Parameters:
NUM_REGS, 32, registers to dump; must be even and at most 2**ADDR_W.
ADDR_W, 5, register address width.
DATA_W, 32, register data width.

Ports:
Clk  input  1  clock, all state updates on the rising edge.
Rst  input  1  asynchronous, active-high reset.
Start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
RdAdr1  output  ADDR_W  drives register_file Adr1 (even register index).
RdAdr2  output  ADDR_W  drives register_file Adr2 (odd register index).
RdData1  input  DATA_W  from register_file Dout1.
RdData2  input  DATA_W  from register_file Dout2.
OutData  output  DATA_W  streamed register value.
OutAdr  output  ADDR_W  index of the register in OutData.
OutValid  output  1  OutData/OutAdr valid.
OutReady  input  1  sink accepts the word when OutValid and OutReady are both high at a rising edge.
Busy  output  1  high in every state except IDLE.
Done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (async, any state, including mid-dump): state=IDLE, pair counter p=0, buffers=0; all outputs 0 (RdAdr1, RdAdr2, OutData, OutAdr, OutValid, Busy, Done).
- States: IDLE, READ, SEND_LO, SEND_HI, DONE.
- IDLE: Busy=0, RdAdr1/RdAdr2=0. Start=1 at an edge: p<=0, go to READ. Start outside IDLE is ignored.
- READ (1 cycle): RdAdr1=2p, RdAdr2=2p+1 (combinational from p). At the edge: buf0<=RdData1, buf1<=RdData2; go to SEND_LO.
- SEND_LO: OutValid=1, OutData=buf0, OutAdr=2p. Accepted (OutReady=1) -> SEND_HI; else hold.
- SEND_HI: OutValid=1, OutData=buf1, OutAdr=2p+1. Accepted: if p==NUM_REGS/2-1 go to DONE, else p<=p+1, go to READ; else hold.
- DONE (1 cycle): Done=1, Busy=1, OutValid=0; then IDLE.
- OutValid is low in IDLE, READ and DONE. While OutValid=1 and OutReady=0, OutData/OutAdr hold stable. OutValid never drops without acceptance except on reset.
- RdAdr1/RdAdr2 hold the last READ address in SEND_* states. Only the value captured in READ is used.
- Latency: Start seen at edge k; READ during cycle k+1; first OutValid in cycle k+2. With OutReady held high, each pair takes 3 cycles. Done pulses in cycle k+2+3*(NUM_REGS/2)-1 (cycle 49 after Start for 32 registers).
- Consistency: each pair is sampled at its own READ cycle. This is not an atomic snapshot; register writes between pairs appear in later pairs.
- Register 0 is dumped as returned by register_file, with no special-casing.

Test Plan:
- Reset then idle: Rst=1 mid-cycle -> all outputs 0 immediately; Start=0 for 10 cycles -> Busy=0, OutValid=0 throughout.
- Full dump, OutReady=1: preload R0=F0F0F0F0, R1=0F0F0F0F, R2=FFFFFFFF, Rn=n otherwise; pulse Start -> 32 words in order, OutAdr 0..31 with matching data; first OutValid 2 cycles after Start; Done pulse exactly once in cycle 49; then Busy=0.
- Backpressure: OutReady low for 5 cycles while OutAdr=1 -> OutData=0F0F0F0F and OutAdr=1 held stable, OutValid=1; no skipped or duplicated words; total word count stays 32.
- Start while busy: pulse Start at word 10 -> ignored; dump still ends after 32 words with a single Done.
- Reset mid-dump: assert Rst during SEND_HI of pair 7 -> outputs 0 asynchronously; a new Start restarts at OutAdr=0.
- Write between pairs: write R20=12345678 after pair 9 is accepted -> word with OutAdr=20 carries 12345678.
